// File: rtl/fc_act_loader_if.sv
// Bus between fc_act_loader and its neighbours: serial activation stream in,
// parallel frame out. The slave modport is the loader side.
interface fc_act_loader_if #(
    parameter int WIDTH = 8,
    parameter int IN    = 128
);
    logic [WIDTH-1:0] s_data;
    logic             s_valid;
    logic             s_last;
    logic             s_ready;
    logic [WIDTH-1:0] x [0:IN-1];
    logic             x_valid;
    logic             x_ack;
    logic             err_len;

    modport slave (
        input  s_data, s_valid, s_last, x_ack,
        output s_ready, x, x_valid, err_len
    );

    modport master (
        output s_data, s_valid, s_last, x_ack,
        input  s_ready, x, x_valid, err_len
    );
endinterface

// File: rtl/fc_act_loader.sv
// Serial-to-parallel activation loader feeding every neuron of an FC layer.
// Define FC_ACT_LOADER_DBUF_EN for ping-pong banks; default is single-buffer FILL/HOLD.
module fc_act_loader #(
    parameter int WIDTH = 8,
    parameter int IN    = 128
) (
    input logic            clk,
    input logic            rst_n,
    fc_act_loader_if.slave bus
);
    localparam int               CNT_W    = $clog2(IN);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(IN - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [IN-1:0]    r_mask;
    logic [WIDTH-1:0] r_buf [0:IN-1];
    logic [WIDTH-1:0] r_x   [0:IN-1];
    logic             r_s_ready;
    logic             r_x_valid;
    logic             r_err_len;

    logic             w_take;
    logic             w_at_end;
    logic             w_done;
    logic             w_err;
    logic [WIDTH-1:0] w_frame [0:IN-1];

    assign w_take   = bus.s_valid & r_s_ready;
    assign w_at_end = (r_cnt == LAST_IDX);
    assign w_done   = w_take & (bus.s_last | w_at_end);
    // short frame (last early) or long frame (no last at the final slot)
    assign w_err    = w_take & (bus.s_last ^ w_at_end);

    assign bus.s_ready = r_s_ready;
    assign bus.x_valid = r_x_valid;
    assign bus.err_len = r_err_len;
    assign bus.x       = r_x;

    // Frame as it looks once the current beat lands; never-written slots read as zero
    always_comb begin
        for (int i = 0; i < IN; i++) begin
            if (w_take && (r_cnt == CNT_W'(i))) begin
                w_frame[i] = bus.s_data;
            end else if (r_mask[i]) begin
                w_frame[i] = r_buf[i];
            end else begin
                w_frame[i] = {WIDTH{1'b0}};
            end
        end
    end

    // Element counter and written-mask, both cleared on frame completion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= {CNT_W{1'b0}};
            r_mask <= {IN{1'b0}};
        end else if (w_done) begin
            r_cnt  <= {CNT_W{1'b0}};
            r_mask <= {IN{1'b0}};
        end else if (w_take) begin
            r_cnt         <= r_cnt + CNT_W'(1);
            r_mask[r_cnt] <= 1'b1;
        end
    end

    // Fill-buffer data; visibility is governed entirely by the mask
    always_ff @(posedge clk) begin
        if (w_take) begin
            r_buf[r_cnt] <= bus.s_data;
        end
    end

`ifndef FC_ACT_LOADER_DBUF_EN
    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t r_state;

    // FILL/HOLD control: presents the completed frame and waits for the consumer ack
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_FILL;
            r_s_ready <= 1'b1;
            r_x_valid <= 1'b0;
            r_err_len <= 1'b0;
            r_x       <= '{default: {WIDTH{1'b0}}};
        end else begin
            r_err_len <= 1'b0;
            case (r_state)
                ST_FILL: begin
                    if (w_done) begin
                        r_state   <= ST_HOLD;
                        r_s_ready <= 1'b0;
                        r_x_valid <= 1'b1;
                        r_err_len <= w_err;
                        r_x       <= w_frame;
                    end
                end
                ST_HOLD: begin
                    if (bus.x_ack) begin
                        r_state   <= ST_FILL;
                        r_s_ready <= 1'b1;
                        r_x_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= ST_FILL;
                    r_s_ready <= 1'b1;
                    r_x_valid <= 1'b0;
                end
            endcase
        end
    end
`else
    logic [WIDTH-1:0] r_bank [0:1][0:IN-1];
    logic [1:0]       r_full;
    logic [1:0]       r_berr;
    logic             r_wr;
    logic             r_rd;
    logic [1:0]       w_full_n;
    logic [1:0]       w_berr_n;
    logic             w_wr_n;
    logic             w_rd_n;
    logic             w_ack_ok;
    logic             w_present;

    // Next bank state; completion and ack may land in the same cycle on different banks
    always_comb begin
        w_full_n = r_full;
        w_berr_n = r_berr;
        w_ack_ok = bus.x_ack & r_x_valid;
        if (w_ack_ok) begin
            w_full_n[r_rd] = 1'b0;
            w_rd_n         = ~r_rd;
        end else begin
            w_rd_n = r_rd;
        end
        if (w_done) begin
            w_full_n[r_wr] = 1'b1;
            w_berr_n[r_wr] = w_err;
            w_wr_n         = ~r_wr;
        end else begin
            w_wr_n = r_wr;
        end
        w_present = w_full_n[w_rd_n] & (~r_x_valid | w_ack_ok);
    end

    // Completed frames land in the bank being written
    always_ff @(posedge clk) begin
        if (w_done) begin
            r_bank[r_wr] <= w_frame;
        end
    end

    // Ping-pong pointers, full flags and registered presentation of the read bank
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full    <= 2'b00;
            r_berr    <= 2'b00;
            r_wr      <= 1'b0;
            r_rd      <= 1'b0;
            r_s_ready <= 1'b1;
            r_x_valid <= 1'b0;
            r_err_len <= 1'b0;
            r_x       <= '{default: {WIDTH{1'b0}}};
        end else begin
            r_full    <= w_full_n;
            r_berr    <= w_berr_n;
            r_wr      <= w_wr_n;
            r_rd      <= w_rd_n;
            r_s_ready <= ~w_full_n[w_wr_n];
            r_x_valid <= w_full_n[w_rd_n];
            r_err_len <= w_present & w_berr_n[w_rd_n];
            if (w_present) begin
                if (w_done && (w_rd_n == r_wr)) begin
                    r_x <= w_frame;
                end else begin
                    r_x <= r_bank[w_rd_n];
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_fc_act_loader.sv
// Randomized scoreboard bench for fc_act_loader: a frame-level model queues
// expected frames as beats are accepted; a monitor pops them as x_valid presents.
`timescale 1ns/1ps
module tb_fc_act_loader;
    localparam int WIDTH = 8;
    localparam int IN    = 128;
    typedef logic [IN-1:0][WIDTH-1:0] frame_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fc_act_loader_if #(.WIDTH(WIDTH), .IN(IN)) bus ();
    fc_act_loader #(.WIDTH(WIDTH), .IN(IN)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int               n_chk = 0;
    int               n_pass = 0;
    frame_t           exp_q[$];
    bit               err_q[$];
    logic [WIDTH-1:0] cur_beats[$];
    int               ack_delay = 0;
    bit               ack_en = 1'b1;
    bit               want_ready = 1'b0;

    function automatic void check(string name, bit ok, logic [31:0] act, logic [31:0] req);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    endfunction

    function automatic void cmp_frame(string name, frame_t f);
        int bad = 0;
        int first = 0;
        for (int i = 0; i < IN; i++) begin
            if (bus.x[i] !== f[i]) begin
                if (bad == 0) first = i;
                bad++;
            end
        end
        check($sformatf("%s[x%0d]", name, first), bad == 0, 32'(bus.x[first]), 32'(f[first]));
    endfunction

    // Frame-level reference: collect accepted beats, close on last or when IN are held
    function automatic void model_accept(logic [WIDTH-1:0] d, logic l);
        frame_t f;
        int     n;
        cur_beats.push_back(d);
        n = cur_beats.size();
        if (l || n == IN) begin
            f = '0;
            foreach (cur_beats[i]) f[i] = cur_beats[i];
            exp_q.push_back(f);
            err_q.push_back(l ? (n < IN) : 1'b1);
            cur_beats.delete();
        end
    endfunction

    task automatic send(input logic [WIDTH-1:0] d, input logic l);
        int waited = 0;
        bus.s_data  = d;
        bus.s_last  = l;
        bus.s_valid = 1'b1;
        while (!bus.s_ready && waited < 3000) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.s_ready) begin
            check("ready_timeout", 1'b0, 32'd0, 32'd1);
            bus.s_valid = 1'b0;
            return;
        end
        model_accept(d, l);
        @(negedge clk);
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || bus.x_valid) && w < 5000) begin
            @(negedge clk);
            w++;
        end
        check("drain", exp_q.size() == 0 && !bus.x_valid, 32'(exp_q.size()), 32'd0);
    endtask

    // Consumer: acks ack_delay cycles into each hold, with occasional stray acks while idle
    initial begin : acker
        int waited = 0;
        bus.x_ack = 1'b0;
        forever begin
            @(negedge clk);
            bus.x_ack = 1'b0;
            if (ack_en && rst_n && bus.x_valid) begin
                if (waited >= ack_delay) begin
                    bus.x_ack = 1'b1;
                    waited = 0;
                end else begin
                    waited++;
                end
            end else begin
                waited = 0;
                if (ack_en && $urandom_range(0, 7) == 0) bus.x_ack = 1'b1;
            end
        end
    end

    initial begin : monitor
        frame_t cur = '0;
        bit cur_err = 1'b0;
        bit prev_v = 1'b0;
        bit prev_ack = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                prev_v = 1'b0;
                prev_ack = 1'b0;
                continue;
            end
            if (bus.x_valid && (!prev_v || prev_ack)) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", 1'b0, 32'd1, 32'd0);
                end else begin
                    cur = exp_q.pop_front();
                    cur_err = err_q.pop_front();
                    cmp_frame("frame", cur);
                    check("err_len_rise", bus.err_len == cur_err, 32'(bus.err_len), 32'(cur_err));
                end
            end else if (bus.x_valid) begin
                cmp_frame("x_stable", cur);
                check("err_len_hold", bus.err_len == 1'b0, 32'(bus.err_len), 32'd0);
            end else begin
                check("err_len_idle", bus.err_len == 1'b0, 32'(bus.err_len), 32'd0);
            end
`ifndef FC_ACT_LOADER_DBUF_EN
            check("s_ready_vs_x_valid", bus.s_ready == !bus.x_valid, 32'(bus.s_ready), 32'(!bus.x_valid));
            if (prev_ack) check("ack_drop", !bus.x_valid, 32'(bus.x_valid), 32'd0);
`endif
            if (want_ready) check("no_bubble", bus.s_ready == 1'b1, 32'(bus.s_ready), 32'd1);
            prev_v = bus.x_valid;
            prev_ack = bus.x_valid & bus.x_ack;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed so far", n_pass, n_chk);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        frame_t zero_f = '0;
        int len;
        logic lst;
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        bus.s_data  = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_x_valid", bus.x_valid == 1'b0, 32'(bus.x_valid), 32'd0);
        check("rst_s_ready", bus.s_ready == 1'b1, 32'(bus.s_ready), 32'd1);
        check("rst_err_len", bus.err_len == 1'b0, 32'(bus.err_len), 32'd0);
        cmp_frame("rst_x", zero_f);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // full frame 1..128, held 10+ cycles
        ack_delay = 10;
        for (int k = 1; k <= IN; k++) send(WIDTH'(k), k == IN);
        #1;
        check("latency_x_valid", bus.x_valid == 1'b1, 32'(bus.x_valid), 32'd1);
        drain();

        // short frame A0..A4
        ack_delay = 2;
        for (int k = 0; k < 5; k++) send(WIDTH'(8'hA0 + k), k == 4);
        drain();

        // long frame: 130 beats without last, then closing beat
        for (int k = 1; k <= 130; k++) send(WIDTH'(k), 1'b0);
        send(WIDTH'(8'h55), 1'b1);
        drain();

        // randomized frames with gaps, backpressure and varied ack delays
        for (int f = 0; f < 10; f++) begin
            ack_delay = $urandom_range(0, 6);
            len = $urandom_range(1, IN + 2);
            for (int b = 0; b < len; b++) begin
                lst = (b == len - 1) && ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 7) == 0) @(negedge clk);
                send(WIDTH'($urandom), lst);
            end
        end
        if (cur_beats.size() != 0) send(WIDTH'($urandom), 1'b1);
        drain();

`ifdef FC_ACT_LOADER_DBUF_EN
        ack_delay = 1;
        want_ready = 1'b1;
        for (int f = 0; f < 3; f++)
            for (int b = 0; b < IN; b++) send(WIDTH'($urandom), b == IN - 1);
        want_ready = 1'b0;
        drain();
        ack_en = 1'b0;
        for (int f = 0; f < 2; f++)
            for (int b = 0; b < 4; b++) send(WIDTH'($urandom), b == 3);
        #1;
        check("dbuf_full_stall", bus.s_ready == 1'b0, 32'(bus.s_ready), 32'd0);
        ack_en = 1'b1;
        drain();
`endif

        // reset in the middle of a fill
        ack_delay = 3;
        for (int k = 0; k < 60; k++) send(WIDTH'(k + 3), 1'b0);
        rst_n = 1'b0;
        #1;
        check("midrst_x_valid", bus.x_valid == 1'b0, 32'(bus.x_valid), 32'd0);
        check("midrst_s_ready", bus.s_ready == 1'b1, 32'(bus.s_ready), 32'd1);
        check("midrst_err_len", bus.err_len == 1'b0, 32'(bus.err_len), 32'd0);
        cmp_frame("midrst_x", zero_f);
        cur_beats.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < IN; k++) send(WIDTH'(k * 3 + 1), k == IN - 1);
        drain();

        check("model_idle", cur_beats.size() == 0, 32'(cur_beats.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/fc_act_loader.md
# fc_act_loader

Sequential activation loader that drives the parallel input bus of a fully-connected layer neuron. It accepts activations one per beat on a valid/ready stream and assembles a frame of IN values. It then presents the frame as a stable, fully parallel array, in the same shape the layer's `x[0:IN-1]` input expects, and holds it until the layer's consumer acknowledges. It sits between the previous layer's serialized output and every neuron instance of the next FC layer.

## Interface
- `WIDTH`, default 8: activation width in bits.
- `IN`, default 128: activations per frame. Must be at least 2.

- `clk`, input, 1: clock; all state updates on the rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `s_data`, input, WIDTH: incoming activation (unsigned post-ReLU value).
- `s_valid`, input, 1: `s_data` is valid.
- `s_last`, input, 1: the current beat is the final element of the frame.
- `s_ready`, output, 1: loader can accept a beat. A beat is taken when `s_valid && s_ready`.
- `x`, output, WIDTH, unpacked `[0:IN-1]`: parallel frame for the layer.
- `x_valid`, output, 1: `x` holds a complete frame.
- `x_ack`, input, 1: consumer has sampled `x`. Honored only while `x_valid` is high.
- `err_len`, output, 1: one-cycle pulse on a frame-length violation.

## Operation
- Element counter `cnt` runs 0..IN-1. Each accepted beat writes `s_data` into fill-buffer entry `cnt` and sets that entry's written-mask bit.
- A frame completes on the accepted beat where `s_last` is high, or where `cnt == IN-1`, whichever comes first. On completion:
  - `cnt` returns to 0.
  - The fill buffer becomes the presented buffer.
  - The mask is cleared for the next fill.
- Presented entries whose mask bit is clear read as 0 on `x`. A truncated frame is therefore zero-padded.
- `err_len` pulses in two cases. In both, the frame still completes normally.
  - `s_last` is high with `cnt < IN-1` (short frame).
  - `s_last` is low with `cnt == IN-1` (long frame). Beats after the forced completion start a new frame.
- Single-buffer mode (macro undefined) has two states:
  - FILL: `s_ready=1`, `x_valid=0`. Goes to HOLD on frame completion.
  - HOLD: `s_ready=0`, `x_valid=1`, `x` stable. Goes to FILL on `x_ack`.
- `x_ack` while in FILL is ignored.
- Arithmetic: there is none on the data. Values pass through bit-exact and are never sign-extended. `cnt` is `$clog2(IN)` bits wide and never wraps past IN-1.

## Timing
- Reset values: `s_ready=1`, `x_valid=0`, `err_len=0`, all `x` entries 0. Also `cnt=0`, state FILL, all masks clear, all bank-full flags clear.
- Reset asserted mid-frame or mid-hold discards all data immediately. Nothing partial is ever presented.
- Latency: `x_valid` rises on the cycle after the completing beat is accepted. `x` equals the new frame in that same cycle.
- `err_len` is registered and high for exactly the cycle in which `x_valid` first rises for the offending frame.
- After `x_ack` is sampled, `x_valid` falls on the next cycle. In single-buffer mode `s_ready` rises in that same cycle.
- `x` changes only on the cycle `x_valid` rises. While `x_valid=1` it does not change.

## Configuration
- Macro `FC_ACT_LOADER_DBUF_EN`. When defined, the loader uses two ping-pong banks, A and B:
  - Each bank has a full flag. `wr_bank` and `rd_bank` start at A.
  - `s_ready = !full[wr_bank]`, and `x_valid = full[rd_bank]`.
  - Completion sets `full[wr_bank]` and toggles `wr_bank`.
  - An honored `x_ack` clears `full[rd_bank]` and toggles `rd_bank`.
  - Completion and ack in the same cycle both take effect.
  - Filling continues while a frame is held. With timely acks the stream sees no bubble.
- When the macro is undefined, the single-buffer FILL/HOLD behavior above applies, with one bank and no fill during HOLD.

## Test plan
- Full frame, IN=128: send beats 1..128 with `s_last` on beat 128, then hold `x_ack=0` for 10 cycles.
  - Response: `x_valid` rises 1 cycle after beat 128 and `x[i]==i+1`.
  - `x` stays stable for the 10 cycles.
  - No `err_len`.
- Short frame: send 5 beats `0xA0..0xA4` with `s_last` on the 5th.
  - Response: `x[0..4]=A0..A4`, `x[5..127]=0`.
  - `err_len` pulses once, coincident with `x_valid` rising.
- Long frame: send 130 beats with `s_last` low throughout.
  - Response: the frame completes at beat 128 with an `err_len` pulse.
  - After ack, beats 129 and 130 appear in `x[0..1]` of the next frame.
- Backpressure (macro undefined): keep `s_valid` high during HOLD.
  - Response: `s_ready=0` and no beat is lost.
  - `x_ack` → `s_ready=1` on the next cycle.
  - The next frame is intact.
- Ping-pong (`FC_ACT_LOADER_DBUF_EN`): stream 3 back-to-back frames, acking each frame 1 cycle after its `x_valid`.
  - Response: `s_ready` never drops and all frames are presented in order.
  - With no acks, `s_ready` drops after frame 2 completes.
- Reset mid-fill: drop `rst_n` after beat 60.
  - Response: outputs return to reset values immediately.
  - A fresh 128-beat frame presents with no stale data.
